// File: rtl/fibonacci_checker_pkg.sv
// Shared types and constants for the Fibonacci stream checker.
// State encoding, default term width and count saturation value.
package fibonacci_checker_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TRACK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam int         DEF_WIDTH = 8;
  localparam logic [7:0] CNT_MAX   = 8'd255;

endpackage

// File: rtl/fib_step_adder.sv
// Ripple-carry adder producing the expected next Fibonacci term.
// Carry-in is zero and the carry-out is dropped (modulo 2^WIDTH).
module fib_step_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic c;

  always_comb begin
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fibonacci_checker.sv
// Checks that each term from the third on is the sum of the previous two.
// Flags the first divergence with a sticky error and the offending term.
module fibonacci_checker
  import fibonacci_checker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit STRICT_SEED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             match,
  output logic             mismatch,
  output logic             error,
  output logic [WIDTH-1:0] fail_data,
  output logic [7:0]       term_count,
  output logic             locked
);

  localparam logic [WIDTH-1:0] SEED1 = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] expected;
  logic [7:0]       cnt_inc;

  fib_step_adder #(.WIDTH(WIDTH)) u_add (
    .a   (prev),
    .b   (cur),
    .sum (expected)
  );

  assign cnt_inc = (term_count == CNT_MAX) ? CNT_MAX : term_count + 8'd1;
  assign locked  = (state == TRACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      prev       <= '0;
      cur        <= '0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      error      <= 1'b0;
      fail_data  <= '0;
      term_count <= '0;
    end else if (restart) begin
      state      <= EMPTY;
      prev       <= '0;
      cur        <= '0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      error      <= 1'b0;
      fail_data  <= '0;
      term_count <= '0;
    end else begin
      match    <= 1'b0;
      mismatch <= 1'b0;
      if (in_valid) begin
        unique case (state)
          EMPTY: begin
            prev       <= in_data;
            term_count <= 8'd1;
            if (STRICT_SEED && in_data != '0) begin
              state     <= FAIL;
              error     <= 1'b1;
              fail_data <= in_data;
              mismatch  <= 1'b1;
            end else begin
              state <= ONE;
            end
          end
          ONE: begin
            cur        <= in_data;
            term_count <= 8'd2;
            if (STRICT_SEED && in_data != SEED1) begin
              state     <= FAIL;
              error     <= 1'b1;
              fail_data <= in_data;
              mismatch  <= 1'b1;
            end else begin
              state <= TRACK;
            end
          end
          TRACK: begin
            term_count <= cnt_inc;
            if (in_data == expected) begin
              prev  <= cur;
              cur   <= in_data;
              match <= 1'b1;
            end else begin
              state     <= FAIL;
              error     <= 1'b1;
              fail_data <= in_data;
              mismatch  <= 1'b1;
            end
          end
          FAIL: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibonacci_checker.sv
// Randomized self-checking bench for fibonacci_checker (strict and loose seeds).
// Reference keeps the accepted stream history and re-derives each check.
module tb_fibonacci_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic       in_valid;
  logic [7:0] in_data;

  logic       match_s, mismatch_s, error_s, locked_s;
  logic [7:0] fail_data_s, count_s;
  logic       match_l, mismatch_l, error_l, locked_l;
  logic [7:0] fail_data_l, count_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fibonacci_checker #(.WIDTH(8), .STRICT_SEED(1'b1)) u_strict (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .match      (match_s),
    .mismatch   (mismatch_s),
    .error      (error_s),
    .fail_data  (fail_data_s),
    .term_count (count_s),
    .locked     (locked_s)
  );

  fibonacci_checker #(.WIDTH(8), .STRICT_SEED(1'b0)) u_loose (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .match      (match_l),
    .mismatch   (mismatch_l),
    .error      (error_l),
    .fail_data  (fail_data_l),
    .term_count (count_l),
    .locked     (locked_l)
  );

  // reference: index 0 = strict instance, 1 = loose instance
  int         hist[$];
  bit         m_failed[2];
  bit         m_match[2];
  bit         m_mis[2];
  bit         m_err[2];
  int         m_fd[2];
  int         m_cnt[2];

  function automatic bit term_ok(int i, int k, int t);
    if (k >= 2) return t == ((hist[k-1] + hist[k-2]) % 256);
    if (i == 0) return (k == 0) ? (t == 0) : (t == 1);
    return 1'b1;
  endfunction

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_failed[i] = 0; m_match[i] = 0; m_mis[i] = 0;
      m_err[i] = 0; m_fd[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_accept(int t);
    int k;
    k = hist.size();
    for (int i = 0; i < 2; i++) begin
      m_match[i] = 0;
      m_mis[i] = 0;
      if (!m_failed[i]) begin
        m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
        if (term_ok(i, k, t)) begin
          m_match[i] = (k >= 2);
        end else begin
          m_failed[i] = 1; m_err[i] = 1; m_fd[i] = t; m_mis[i] = 1;
        end
      end
    end
    hist.push_back(t);
  endtask

  function automatic logic [19:0] exp_vec(int i);
    bit lk;
    lk = !m_failed[i] && hist.size() >= 2;
    return {m_match[i], m_mis[i], m_err[i], lk, 8'(m_fd[i]), 8'(m_cnt[i])};
  endfunction

  function automatic logic [19:0] obs_vec(int i);
    if (i == 0)
      return {match_s, mismatch_s, error_s, locked_s, fail_data_s, count_s};
    return {match_l, mismatch_l, error_l, locked_l, fail_data_l, count_l};
  endfunction

  task automatic step(bit v, int d, bit r);
    @(negedge clk);
    in_valid = v;
    in_data  = 8'(d);
    restart  = r;
    @(posedge clk);
    #1;
    if (r) model_clear();
    else if (v) model_accept(d);
    else begin
      for (int i = 0; i < 2; i++) begin m_match[i] = 0; m_mis[i] = 0; end
    end
    in_valid = 0;
    restart  = 0;
  endtask

  task automatic test_reset();
    reset = 0; restart = 0; in_valid = 0; in_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== 20'h0) begin
        failures++;
        $display("FAIL reset inst%0d got %h exp %h", i, obs_vec(i), 20'h0);
      end
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_basic();
    int seq[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
    int nm = 0;
    int nmm = 0;
    for (int j = 0; j < 8; j++) begin
      step(1, seq[j], 0);
      nm += int'(match_s);
      nmm += int'(mismatch_s);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL basic inst%0d t%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
      if (j >= 1) begin
        checks++;
        if (locked_s !== 1'b1) begin
          failures++;
          $display("FAIL basic_locked t%0d got %b exp 1", j, locked_s);
        end
      end
    end
    checks++;
    if (nm != 6 || nmm != 0 || count_s !== 8'd8 || error_s !== 1'b0) begin
      failures++;
      $display("FAIL basic_totals got m=%0d mm=%0d cnt=%0d err=%b exp 6 0 8 0", nm, nmm, count_s, error_s);
    end
  endtask

  task automatic test_wrap();
    int a = 0;
    int b = 1;
    int t;
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    for (int j = 0; j < 14; j++) begin
      t = (a + b) % 256;
      a = b; b = t;
      step(1, t, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL wrap inst%0d t%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
      if (t == 121 || t == 98) begin
        checks++;
        if (match_s !== 1'b1 || error_s !== 1'b0) begin
          failures++;
          $display("FAIL wrap_term%0d got m=%b e=%b exp m=1 e=0", t, match_s, error_s);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    int seq[7] = '{0, 1, 1, 2, 4, 6, 10};
    step(1, 0, 1);
    for (int j = 0; j < 7; j++) begin
      step(1, seq[j], 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL mismatch inst%0d t%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
      if (j == 4) begin
        checks++;
        if (mismatch_s !== 1'b1) begin
          failures++;
          $display("FAIL mismatch_pulse got %b exp 1", mismatch_s);
        end
      end
    end
    checks++;
    if (error_s !== 1'b1 || fail_data_s !== 8'd4 || count_s !== 8'd5) begin
      failures++;
      $display("FAIL mismatch_sticky got e=%b fd=%0d cnt=%0d exp 1 4 5", error_s, fail_data_s, count_s);
    end
  endtask

  task automatic test_seed();
    int seq[4] = '{3, 4, 7, 11};
    int nm = 0;
    step(1, 0, 1);
    step(1, 1, 0);
    checks++;
    if (error_s !== 1'b1 || fail_data_s !== 8'd1 || error_l !== 1'b0) begin
      failures++;
      $display("FAIL seed_strict got e=%b fd=%0d el=%b exp 1 1 0", error_s, fail_data_s, error_l);
    end
    step(1, 0, 1);
    for (int j = 0; j < 4; j++) begin
      step(1, seq[j], 0);
      nm += int'(match_l);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL seed inst%0d t%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
    end
    checks++;
    if (nm != 2 || error_l !== 1'b0) begin
      failures++;
      $display("FAIL seed_loose got m=%0d e=%b exp 2 0", nm, error_l);
    end
  endtask

  task automatic test_restart_in_fail();
    int nm = 0;
    checks++;
    if (error_s !== 1'b1) begin
      failures++;
      $display("FAIL restart_pre got e=%b exp 1", error_s);
    end
    step(1, 5, 1);
    checks++;
    if (error_s !== 1'b0 || count_s !== 8'd0 || locked_s !== 1'b0 || fail_data_s !== 8'd0) begin
      failures++;
      $display("FAIL restart_clear got e=%b cnt=%0d lk=%b fd=%0d exp 0 0 0 0", error_s, count_s, locked_s, fail_data_s);
    end
    for (int j = 0; j < 3; j++) begin
      step(1, (j == 0) ? 0 : 1, 0);
      nm += int'(match_s);
    end
    checks++;
    if (nm != 1 || count_s !== 8'd3 || obs_vec(0) !== exp_vec(0)) begin
      failures++;
      $display("FAIL restart_after got m=%0d cnt=%0d exp 1 3", nm, count_s);
    end
  endtask

  task automatic test_async_reset();
    int seq[6] = '{0, 1, 1, 2, 3, 5};
    int nm = 0;
    step(1, 0, 1);
    for (int j = 0; j < 6; j++) step(1, seq[j], 0);
    checks++;
    if (count_s !== 8'd6 || locked_s !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got cnt=%0d lk=%b exp 6 1", count_s, locked_s);
    end
    @(negedge clk);
    #1 reset = 0;
    #1;
    model_clear();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== 20'h0) begin
        failures++;
        $display("FAIL async inst%0d got %h exp %h", i, obs_vec(i), 20'h0);
      end
    end
    @(negedge clk);
    reset = 1;
    for (int j = 0; j < 3; j++) begin
      step(1, (j == 0) ? 0 : 1, 0);
      nm += int'(match_s);
    end
    checks++;
    if (nm != 1 || obs_vec(0) !== exp_vec(0)) begin
      failures++;
      $display("FAIL async_after got m=%0d exp 1", nm);
    end
  endtask

  task automatic test_saturation();
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    for (int j = 0; j < 270; j++) begin
      step(1, (hist[$] + hist[$-1]) % 256, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL sat inst%0d t%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
    end
    checks++;
    if (count_s !== 8'd255 || match_s !== 1'b1) begin
      failures++;
      $display("FAIL sat_end got cnt=%0d m=%b exp 255 1", count_s, match_s);
    end
  endtask

  task automatic test_random();
    int d;
    bit v;
    bit r;
    step(1, 0, 1);
    for (int j = 0; j < 600; j++) begin
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (hist.size() == 0) d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0;
      else if (hist.size() == 1) d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 1;
      else d = (hist[$] + hist[$-1]) % 256;
      if ($urandom_range(0, 29) == 0) d = (d + int'($urandom_range(1, 255))) % 256;
      step(v, d, r);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL random inst%0d s%0d got %h exp %h", i, j, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mismatch();
    test_seed();
    test_restart_in_fail();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fibonacci_checker.md
# fibonacci_checker

Stream checker that consumes an 8-bit value sequence, one term per valid cycle, and verifies that every term from the third onward equals the modulo-2^WIDTH sum of the two preceding terms. It sits on the output side of the Fibonacci generator: it closes the loop in self-checking builds and flags the first divergence. It also serves as a standalone monitor for any externally supplied sequence. The block computes the expected next term with its own ripple-carry stage and is fully registered.

## Interface
- WIDTH, 8: term width in bits. All arithmetic is modulo 2^WIDTH.
- STRICT_SEED, 1: when 1, the first two terms must be 0 then 1. When 0, any two seed terms are accepted.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- restart  input  1  synchronous clear back to the empty state.
- in_valid  input  1  in_data holds a term this cycle.
- in_data  input  WIDTH  term value.
- match  output  1  one-cycle pulse: the last accepted third-or-later term was correct.
- mismatch  output  1  one-cycle pulse: the last accepted term failed its check.
- error  output  1  sticky failure flag.
- fail_data  output  WIDTH  term that caused the failure.
- term_count  output  8  accepted terms; saturates at 255.
- locked  output  1  state is TRACK (two seeds held).

## Operation
- States:
  - EMPTY: no terms held.
  - ONE: prev held.
  - TRACK: prev and cur held.
  - FAIL: check failed; stream is ignored.
- EMPTY, in_valid:
  - prev <= in_data; count <= 1.
  - STRICT_SEED=1 and in_data != 0 → FAIL.
  - Otherwise → ONE.
- ONE, in_valid:
  - cur <= in_data; count <= 2.
  - STRICT_SEED=1 and in_data != 1 → FAIL.
  - Otherwise → TRACK.
- TRACK, in_valid:
  - expected = (prev + cur) mod 2^WIDTH; carry out is discarded.
  - in_data == expected: prev <= cur, cur <= in_data, count++, match pulse.
  - Otherwise → FAIL.
- Entry to FAIL (from any state): error <= 1, fail_data <= in_data, mismatch pulse. count is incremented (the failing term counts as accepted).
- FAIL: in_valid is ignored. Leave only by restart or reset.
- restart has priority over in_valid in the same cycle. It takes the block to EMPTY and clears prev, cur, count, error, fail_data and both pulses. The term on in_data in that cycle is discarded.
- in_valid=0: no state change; match and mismatch return to 0.

## Timing
- All outputs are registered. Latency is 1 cycle: term accepted at edge N → match, mismatch, count, locked and error are visible after edge N.
- Back-to-back terms are supported every cycle. There is no backpressure and no ready signal.
- Reset values (asynchronous, on reset=0):
  - state EMPTY; prev = cur = 0.
  - match = mismatch = error = locked = 0.
  - fail_data = 0; term_count = 0.
- Reset asserted mid-stream: all state is cleared immediately, without waiting for a clock edge. The first valid cycle after release is treated as the first seed.
- term_count saturates at 255 and keeps checking. Wrap of term values is legal (233, 144 → 121 for WIDTH=8).
- match and mismatch are mutually exclusive and never assert in the same cycle as restart's effect.

## Structure
- Shared package holds:
  - the state encoding constants: EMPTY = 2'd0, ONE = 2'd1, TRACK = 2'd2, FAIL = 2'd3;
  - the default WIDTH;
  - the count saturation value 8'd255.
- One sub-module: fib_step_adder, a WIDTH-bit ripple-carry adder with carry-in tied to 0 and carry-out left unused. It computes expected from prev and cur.
- The comparator, FSM and counters live in fibonacci_checker.

## Test plan
- Reset, then 0,1,1,2,3,5,8,13 on consecutive cycles:
  - 6 match pulses, 0 mismatch;
  - term_count=8, error=0;
  - locked=1 from the cycle after the second term.
- Wrap: feed the generator sequence through 144,233,121,98:
  - match on 121 and on 98;
  - no error; carry ignored.
- Mismatch: 0,1,1,2,4:
  - mismatch pulse the cycle after 4;
  - error=1, fail_data=4, term_count=5;
  - further terms (e.g. 6, 10) change nothing.
- Seed checks:
  - STRICT_SEED=1 with first term 1 → FAIL after the first term, fail_data=1.
  - STRICT_SEED=0 with seeds 3,4 then 7,11 → 2 matches.
- restart and in_valid with in_data=5 in the same cycle while in FAIL:
  - result is EMPTY with error=0, count=0;
  - the 5 is not captured;
  - a subsequent 0,1,1 gives 1 match.
- Reset asserted asynchronously between edges while in TRACK with count=6: all outputs are 0 before the next edge; after release, 0,1,1 gives 1 match.
